// File: rtl/fetch_unit.sv
// Instruction fetch unit: keeps at most one memory request in flight, honours execute-stage
// redirects in every state and hands one instruction at a time to the datapath (valid/ready).
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] Instr,
    output logic [31:0] pc_out
);

    localparam logic [31:0] NopInstr = 32'h0000_0013;
    localparam logic [31:0] ResetPc  = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        StFetch,
        StWait,
        StHold,
        StDrain
    } state_e;

    state_e      state_q;
    logic        req_q;
    logic [31:0] pc_q;
    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] pc_out_q;

    logic [31:0] redirect_target;
    logic [31:0] pc_seq;
    logic        unused_redirect_lsb;

    assign redirect_target     = {redirect_pc[31:2], 2'b00};
    assign pc_seq              = pc_q + 32'd4;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Memory-side outputs come straight from flops, so no input reaches them combinationally.
    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign Instr       = instr_q;
    assign pc_out      = pc_out_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StFetch;
            req_q    <= 1'b0;
            pc_q     <= ResetPc;
            valid_q  <= 1'b0;
            instr_q  <= NopInstr;
            pc_out_q <= ResetPc;
        end else begin
            unique case (state_q)
                // req_q is low in FETCH only straight after reset; the request is armed first.
                StFetch: begin
                    if (redirect) begin
                        pc_q <= redirect_target;
                        if (req_q) begin
                            state_q <= StDrain;
                            req_q   <= 1'b0;
                        end else begin
                            req_q <= 1'b1;
                        end
                    end else if (req_q) begin
                        state_q <= StWait;
                        req_q   <= 1'b0;
                    end else begin
                        req_q <= 1'b1;
                    end
                end
                StWait: begin
                    if (redirect) begin
                        pc_q <= redirect_target;
                        if (imem_rvalid) begin
                            state_q <= StFetch;
                            req_q   <= 1'b1;
                        end else begin
                            state_q <= StDrain;
                        end
                    end else if (imem_rvalid) begin
                        state_q  <= StHold;
                        instr_q  <= imem_rdata;
                        pc_out_q <= pc_q;
                        valid_q  <= 1'b1;
                    end
                end
                StHold: begin
                    if (redirect) begin
                        pc_q    <= redirect_target;
                        valid_q <= 1'b0;
                        state_q <= StFetch;
                        req_q   <= 1'b1;
                    end else if (instr_ready) begin
                        pc_q    <= pc_seq;
                        valid_q <= 1'b0;
                        state_q <= StFetch;
                        req_q   <= 1'b1;
                    end
                end
                StDrain: begin
                    if (redirect) begin
                        pc_q <= redirect_target;
                    end
                    // A response coinciding with a redirect still retires the stale request;
                    // waiting for another one would deadlock.
                    if (imem_rvalid) begin
                        state_q <= StFetch;
                        req_q   <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a latency-variable memory and a program-flow reference
// (expected PC sequence with redirects) check every request and every delivered instruction.
module tb_fetch_unit;

    localparam logic [31:0] ResetPc = 32'h0000_0000;
    localparam logic [31:0] Nop     = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] Instr;
    logic [31:0] pc_out;

    fetch_unit #(
        .RESET_PC(ResetPc)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .Instr      (Instr),
        .pc_out     (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus knobs
    int unsigned ready_pct = 100;
    int unsigned redir_pct = 0;
    int unsigned spur_pct  = 0;
    int unsigned lat_min   = 1;
    int unsigned lat_max   = 1;
    logic        redir_force = 1'b0;
    logic [31:0] redir_force_pc = '0;

    // Reference state: where the program should be fetching from
    logic [31:0] model_pc;
    int          delivered;
    int          since_progress;
    logic        mem_pending;
    logic [31:0] mem_addr;
    int unsigned mem_cnt;

    // Last sampled outputs and previous-cycle context
    int          cyc = 0;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_instr, s_pc;
    logic        prev_req, p_valid, p_ready, p_redirect;
    logic [31:0] p_instr, p_pc;

    logic [31:0] req_adr[$];
    int          req_cyc[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %08h expected %08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic reset_model();
        model_pc       = ResetPc;
        mem_pending    = 1'b0;
        mem_cnt        = 0;
        since_progress = 0;
        prev_req       = 1'b0;
        p_valid        = 1'b0;
        p_ready        = 1'b0;
        p_redirect     = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        redirect       = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
    endtask

    // One clock: sample on the falling edge, check, then drive inputs for the next rising edge.
    task automatic step();
        logic        redir, rdy, rv;
        logic [31:0] tgt, rd;
        @(negedge clk);
        cyc++;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = instr_valid;
        s_instr = Instr;
        s_pc    = pc_out;

        if (s_req) begin
            req_adr.push_back(s_addr);
            req_cyc.push_back(cyc);
            check_eq("req_addr", s_addr, model_pc);
            check_eq("req_single_cycle", 32'(prev_req), 32'd0);
            check_eq("req_outstanding", 32'(mem_pending), 32'd0);
            check_eq("req_while_valid", 32'(s_valid), 32'd0);
        end
        if (s_valid) begin
            check_eq("pc_out", s_pc, model_pc);
            check_eq("instr", s_instr, mem_word(s_pc));
        end
        if (p_redirect) check_eq("redirect_kills_valid", 32'(s_valid), 32'd0);
        if (p_valid && !p_ready && !p_redirect) begin
            check_eq("hold_valid", 32'(s_valid), 32'd1);
            check_eq("hold_instr", s_instr, p_instr);
            check_eq("hold_pc", s_pc, p_pc);
        end
        since_progress = s_valid ? 0 : since_progress + 1;
        check_eq("stall_bound", 32'(since_progress <= 60), 32'd1);

        // Memory: single outstanding request, fixed latency per request
        rv = 1'b0;
        rd = $urandom;
        if (mem_pending) begin
            if (mem_cnt == 1) begin
                rv          = 1'b1;
                rd          = mem_word(mem_addr);
                mem_pending = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        if (s_req) begin
            mem_pending = 1'b1;
            mem_addr    = s_addr;
            mem_cnt     = lat_min + $urandom_range(lat_max - lat_min);
        end else if (!mem_pending && !rv && $urandom_range(99) < spur_pct) begin
            rv = 1'b1;  // unsolicited strobe, must be ignored
        end

        redir = redir_force || ($urandom_range(99) < redir_pct);
        tgt   = redir_force ? redir_force_pc : $urandom;
        redir_force = 1'b0;
        rdy   = $urandom_range(99) < ready_pct;

        imem_rvalid = rv;
        imem_rdata  = rd;
        redirect    = redir;
        redirect_pc = tgt;
        instr_ready = rdy;

        // Program flow at the coming edge
        if (s_valid && rdy) delivered++;
        if (redir) model_pc = {tgt[31:2], 2'b00};
        else if (s_valid && rdy) model_pc = model_pc + 32'd4;

        prev_req   = s_req;
        p_valid    = s_valid;
        p_ready    = rdy;
        p_redirect = redir;
        p_instr    = s_instr;
        p_pc       = s_pc;
    endtask

    task automatic wait_valid(input string tag, input int bound);
        int n = 0;
        do begin
            step();
            n++;
        end while (!s_valid && n < bound);
        check_eq(tag, 32'(s_valid), 32'd1);
    endtask

    task automatic wait_req(input string tag, input int bound);
        int n = 0;
        do begin
            step();
            n++;
        end while (!s_req && n < bound);
        check_eq(tag, 32'(s_req), 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check_eq({tag, "_instr"}, Instr, Nop);
        check_eq({tag, "_pc_out"}, pc_out, ResetPc);
        check_eq({tag, "_req"}, 32'(imem_req), 32'd0);
        check_eq({tag, "_addr"}, imem_addr, ResetPc);
    endtask

    initial begin
        delivered = 0;
        reset_model();
        reset = 1'b1;
        #1 reset = 1'b0;
        #22;
        check_reset_state("reset");

        // Release, latency 1, always ready: addresses 0,4,8 spaced three cycles apart
        @(negedge clk);
        reset = 1'b1;
        req_adr.delete();
        req_cyc.delete();
        step();
        check_eq("first_req", 32'(s_req), 32'd1);
        check_eq("first_addr", s_addr, ResetPc);
        for (int i = 0; i < 30 && req_adr.size() < 3; i++) step();
        check_eq("tput_count", 32'(req_adr.size()), 32'd3);
        if (req_adr.size() >= 3) begin
            check_eq("tput_addr1", req_adr[1], 32'h4);
            check_eq("tput_addr2", req_adr[2], 32'h8);
            check_eq("tput_gap1", 32'(req_cyc[1] - req_cyc[0]), 32'd3);
            check_eq("tput_gap2", 32'(req_cyc[2] - req_cyc[1]), 32'd3);
        end
        check_eq("tput_delivered", 32'(delivered), 32'd2);

        // Stall in HOLD on a known instruction for five cycles
        ready_pct      = 0;
        redir_force    = 1'b1;
        redir_force_pc = 32'h0000_0040;
        step();
        wait_valid("hold_reach", 20);
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("stall_valid", 32'(s_valid), 32'd1);
            check_eq("stall_instr", s_instr, 32'h0050_0093);
            check_eq("stall_pc", s_pc, 32'h0000_0040);
            check_eq("stall_noreq", 32'(s_req), 32'd0);
        end

        // PC wraps from the top of the address space
        redir_force    = 1'b1;
        redir_force_pc = 32'hFFFF_FFFC;
        step();
        wait_valid("wrap_reach", 20);
        check_eq("wrap_pc", s_pc, 32'hFFFF_FFFC);
        ready_pct = 100;
        req_adr.delete();
        wait_req("wrap_req", 10);
        if (req_adr.size() > 0) check_eq("wrap_addr", req_adr[0], 32'h0000_0000);

        // Redirect during WAIT with slow memory: stale response drained and dropped
        lat_min = 4;
        lat_max = 4;
        wait_req("drain_req", 20);
        redir_force    = 1'b1;
        redir_force_pc = 32'h0000_0102;
        step();
        req_adr.delete();
        for (int i = 0; i < 20 && req_adr.size() == 0; i++) begin
            step();
            check_eq("drain_valid", 32'(s_valid), 32'd0);
        end
        check_eq("drain_req_seen", 32'(req_adr.size()), 32'd1);
        if (req_adr.size() > 0) check_eq("drain_addr", req_adr[0], 32'h0000_0100);
        wait_valid("drain_deliver", 20);
        check_eq("drain_pc", s_pc, 32'h0000_0100);
        check_eq("drain_instr", s_instr, mem_word(32'h0000_0100));

        // Redirect together with the response in WAIT
        lat_min = 1;
        lat_max = 1;
        wait_req("same_req", 20);
        redir_force    = 1'b1;
        redir_force_pc = 32'h0000_0200;
        step();
        step();
        check_eq("same_req_next", 32'(s_req), 32'd1);
        check_eq("same_addr", s_addr, 32'h0000_0200);
        check_eq("same_valid", 32'(s_valid), 32'd0);

        // Randomized traffic
        lat_min   = 1;
        lat_max   = 4;
        ready_pct = 60;
        redir_pct = 6;
        spur_pct  = 10;
        for (int i = 0; i < 1500; i++) step();

        // Asynchronous reset while holding an instruction
        ready_pct = 0;
        redir_pct = 0;
        spur_pct  = 0;
        wait_valid("async_reach", 30);
        #2 reset = 1'b0;
        #1;
        check_reset_state("async");
        @(negedge clk);
        reset_model();
        @(negedge clk);
        reset = 1'b1;
        step();
        check_eq("rerun_req", 32'(s_req), 32'd1);
        check_eq("rerun_addr", s_addr, ResetPc);
        ready_pct = 100;
        for (int i = 0; i < 12; i++) step();

        check_eq("delivered_some", 32'(delivered > 50), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset; bits [1:0] SHALL be zero.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low; reset==0 SHALL force reset state immediately, independent of clk.
REQ-004 imem_req  output  1  fetch request to instruction memory, valid for one cycle per request.
REQ-005 imem_addr  output  32  word-aligned fetch address, qualified by imem_req.
REQ-006 imem_rvalid  input  1  memory response strobe; imem_rdata is valid in the same cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 redirect  input  1  branch/jump redirect request from the execute stage.
REQ-009 redirect_pc  input  32  redirect target, used only when redirect==1.
REQ-010 instr_valid  output  1  Instr and pc_out hold a valid instruction for the datapath.
REQ-011 instr_ready  input  1  datapath accepts the instruction this cycle.
REQ-012 Instr  output  32  instruction word to the datapath and decoder.
REQ-013 pc_out  output  32  address of the instruction currently on Instr.

Function
REQ-014 The FSM SHALL have states FETCH, WAIT, HOLD and DRAIN, with one outstanding memory request at most.
REQ-015 FETCH: imem_req=1 and imem_addr=PC for exactly one cycle, then WAIT.
REQ-016 WAIT: on imem_rvalid, Instr<=imem_rdata, pc_out<=PC, and instr_valid<=1 next cycle, then HOLD; otherwise stay in WAIT with no timeout.
REQ-017 HOLD: Instr, pc_out and instr_valid SHALL stay stable while instr_ready==0.
REQ-018 HOLD with instr_ready==1: the handshake completes, PC<=PC+4, instr_valid<=0, then FETCH.
REQ-019 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-020 Redirect SHALL have the highest priority in every state: PC<={redirect_pc[31:2],2'b00} and instr_valid<=0 next cycle.
REQ-021 Redirect in FETCH or HOLD SHALL go to FETCH; a request already issued in that FETCH cycle SHALL be treated as in flight, so the FSM goes to DRAIN instead.
REQ-022 Redirect in WAIT without imem_rvalid SHALL go to DRAIN; with imem_rvalid in the same cycle, the response SHALL be discarded and the FSM goes to FETCH.
REQ-023 DRAIN: imem_req=0; the next imem_rvalid SHALL be discarded (Instr unchanged), then FETCH; redirect in DRAIN SHALL update PC and stay in DRAIN.
REQ-024 Redirect and instr_ready both 1 in HOLD: the handshake completes (instruction consumed) and PC takes the redirect target, not PC+4.
REQ-025 imem_rvalid in FETCH or HOLD SHALL be ignored.
REQ-026 Minimum throughput: one instruction per 3 cycles (FETCH, WAIT with rvalid one cycle after request, HOLD with ready=1).
REQ-027 imem_req and imem_addr SHALL be decoded from registered state only, with no combinational path from any input.

Reset
REQ-028 While reset==0: PC=RESET_PC, state=FETCH, imem_req=0, imem_addr=RESET_PC, instr_valid=0, Instr=32'h0000_0013 (NOP), pc_out=RESET_PC.
REQ-029 First rising clk after reset==1: imem_req=1 with imem_addr=RESET_PC.
REQ-030 Reset mid-WAIT or mid-DRAIN SHALL abandon the in-flight request; instruction memory shares this reset, so no stale response arrives.

Verification
REQ-031 Reset release, memory latency 1, instr_ready tied 1 -> imem_addr sequence 0,4,8 and Instr matches memory contents, one instruction per 3 cycles.
REQ-032 instr_ready=0 for 5 cycles in HOLD with Instr=32'h00500093 -> Instr, pc_out and instr_valid stable for all 5 cycles, no new imem_req.
REQ-033 Redirect to 32'h0000_0102 during WAIT, memory latency 4 -> DRAIN, the stale response is dropped, next imem_addr=32'h0000_0100, and instr_valid stays 0 until that response.
REQ-034 Redirect and imem_rvalid in the same WAIT cycle -> response discarded, FETCH at the redirect target next cycle.
REQ-035 PC=32'hFFFF_FFFC, handshake completes -> next imem_addr=32'h0000_0000.
REQ-036 reset pulled low asynchronously mid-HOLD -> instr_valid=0, Instr=32'h0000_0013, pc_out=RESET_PC before the next clk edge.
